// File: rtl/ctrl_regs_axil.sv
// ctrl_regs_axil
// AXI4-Lite register slave that lets the PS run the accelerator's global
// controller: it raises ap_start with a shadowed K dimension, records done
// pulses and raises a level interrupt.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*           AXI-Lite write address/data/response channels
//   s_axil_ar*/r*              AXI-Lite read address/data channels
//   ap_start                   start level to the controller, held until done
//   cfg_k_dim                  K dimension captured when a run starts
//   ap_done                    one-cycle completion pulse from the controller
//   ap_idle                    controller idle level
//   irq                        done_sticky & irq_en
//
// Register map (byte offset, addr[4:2] decoded)
//   0x00 CTRL     bit0 START (reads ap_start), bit7 AUTO_RESTART (optional)
//   0x04 STATUS   bit0 DONE (W1C, sticky), bit1 IDLE, bit2 BUSY
//   0x08 IRQ_EN   bit0
//   0x0C K_DIM    32-bit, byte strobes honoured
//   0x10 DONE_CNT 32-bit read-only
//
// Build option: define CTRL_AUTO_RESTART_EN to implement CTRL.AUTO_RESTART.

module ctrl_regs_axil #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] K_DIM_RST = 32'd192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              ap_start,
    output logic [31:0]       cfg_k_dim,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic              irq
);

    logic        aw_rdy_q, ar_rdy_q, bvalid_q, rvalid_q;
    logic [31:0] rdata_q, rd_mux;
    logic        ap_start_q, done_q, irq_en_q;
    logic [31:0] cfg_q, k_dim_q, done_cnt_q;
    logic        auto_bit, restart;

    logic        wr_fire, rd_fire, rvalid_nxt;
    logic [2:0]  wr_idx, rd_idx;
    logic        wr_ctrl, wr_status, wr_irq_en, wr_k_dim;
    logic        start_req, load;

    // Address bits outside [4:2] and upper data bits of narrow registers.
    logic        unused_ok;
    assign unused_ok = &{1'b0, s_axil_awaddr, s_axil_araddr, s_axil_wdata};

    assign wr_fire    = aw_rdy_q & s_axil_awvalid & s_axil_wvalid;
    assign rd_fire    = ar_rdy_q & s_axil_arvalid;
    assign rvalid_nxt = rd_fire | (rvalid_q & ~s_axil_rready);
    assign wr_idx     = s_axil_awaddr[4:2];
    assign rd_idx     = s_axil_araddr[4:2];

    assign wr_ctrl   = wr_fire && (wr_idx == 3'd0);
    assign wr_status = wr_fire && (wr_idx == 3'd1);
    assign wr_irq_en = wr_fire && (wr_idx == 3'd2);
    assign wr_k_dim  = wr_fire && (wr_idx == 3'd3);

    assign start_req = wr_ctrl & s_axil_wdata[0] & ~ap_start_q & ap_idle;
    assign load      = start_req | restart;

`ifdef CTRL_AUTO_RESTART_EN
    logic auto_q, pend_q;

    // pend_q remembers that a run finished, so a restart only follows a done
    // and never fires from plain idle.
    assign restart  = auto_q & pend_q & ~ap_start_q & ap_idle;
    assign auto_bit = auto_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            if (wr_ctrl)
                auto_q <= s_axil_wdata[7];
            if (!auto_q)
                pend_q <= 1'b0;
            else if (ap_done)
                pend_q <= 1'b1;
            else if (load)
                pend_q <= 1'b0;
        end
    end
`else
    assign restart  = 1'b0;
    assign auto_bit = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (rd_idx)
            3'd0: rd_mux = {24'd0, auto_bit, 6'd0, ap_start_q};
            3'd1: rd_mux = {29'd0, ap_start_q, ap_idle, done_q};
            3'd2: rd_mux = {31'd0, irq_en_q};
            3'd3: rd_mux = k_dim_q;
            3'd4: rd_mux = done_cnt_q;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_rdy_q   <= 1'b0;
            ar_rdy_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            ap_start_q <= 1'b0;
            cfg_q      <= K_DIM_RST;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            k_dim_q    <= K_DIM_RST;
            done_cnt_q <= 32'd0;
        end else begin
            // One-cycle ready pulse; ~aw_rdy_q stops a held request being taken twice.
            aw_rdy_q <= s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~aw_rdy_q;
            if (wr_fire)
                bvalid_q <= 1'b1;
            else if (s_axil_bready)
                bvalid_q <= 1'b0;

            rvalid_q <= rvalid_nxt;
            ar_rdy_q <= ~rvalid_nxt;
            if (rd_fire)
                rdata_q <= rd_mux;

            if (ap_done)
                ap_start_q <= 1'b0;
            else if (load) begin
                ap_start_q <= 1'b1;
                cfg_q      <= k_dim_q;
            end

            // A coincident W1C loses to a new done.
            if (ap_done)
                done_q <= 1'b1;
            else if (wr_status && s_axil_wdata[0])
                done_q <= 1'b0;

            if (ap_done)
                done_cnt_q <= done_cnt_q + 32'd1;

            if (wr_irq_en)
                irq_en_q <= s_axil_wdata[0];

            if (wr_k_dim)
                for (int b = 0; b < 4; b++)
                    if (s_axil_wstrb[b])
                        k_dim_q[8*b +: 8] <= s_axil_wdata[8*b +: 8];
        end
    end

    assign s_axil_awready = aw_rdy_q;
    assign s_axil_wready  = aw_rdy_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_arready = ar_rdy_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;
    assign ap_start       = ap_start_q;
    assign cfg_k_dim      = cfg_q;
    assign irq            = done_q & irq_en_q;

endmodule

// File: tb/tb_ctrl_regs_axil.sv
module tb_ctrl_regs_axil;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata, cfg_k_dim;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        ap_start, ap_done, ap_idle, irq;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents.
    logic        m_start, m_done, m_irqen, m_auto;
    logic [31:0] m_cfg, m_k, m_cnt;

    ctrl_regs_axil dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready),
        .ap_start(ap_start), .cfg_k_dim(cfg_k_dim), .ap_done(ap_done),
        .ap_idle(ap_idle), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_start = 0; m_done = 0; m_irqen = 0; m_auto = 0;
        m_cfg = 32'd192; m_k = 32'd192; m_cnt = 0;
    endfunction

    function automatic void m_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        case (a[4:2])
            3'd0: begin
`ifdef CTRL_AUTO_RESTART_EN
                m_auto = d[7];
`endif
                if (d[0] && !m_start && ap_idle) begin
                    m_start = 1;
                    m_cfg   = m_k;
                end
            end
            3'd1: if (d[0]) m_done = 0;
            3'd2: m_irqen = d[0];
            3'd3: for (int b = 0; b < 4; b++) if (s[b]) m_k[8*b +: 8] = d[8*b +: 8];
            default: ;
        endcase
    endfunction

    function automatic void m_done_evt();
        m_start = 0;
        m_done  = 1;
        m_cnt   = m_cnt + 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        case (a[4:2])
            3'd0: return {24'd0, m_auto, 6'd0, m_start};
            3'd1: return {29'd0, m_start, ap_idle, m_done};
            3'd2: return {31'd0, m_irqen};
            3'd3: return m_k;
            3'd4: return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".ap_start"}, {31'd0, ap_start}, {31'd0, m_start});
        chk({tag, ".cfg_k_dim"}, cfg_k_dim, m_cfg);
        chk({tag, ".irq"}, {31'd0, irq}, {31'd0, m_done & m_irqen});
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int hold, input bit with_done);
        int n;
        @(negedge clk);
        awaddr = a; awvalid = 1;
        repeat (lead) begin
            @(negedge clk);
            chk("aw_only_no_ready", {31'd0, awready}, 32'd0);
        end
        wdata = d; wstrb = s; wvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        chk("aw_ready_seen", {31'd0, awready}, 32'd1);
        chk("w_ready_seen", {31'd0, wready}, 32'd1);
        if (with_done) ap_done = 1;
        m_write(a, d, s);
        if (with_done) m_done_evt();
        @(negedge clk);
        awvalid = 0; wvalid = 0; ap_done = 0;
        chk("bvalid_up", {31'd0, bvalid}, 32'd1);
        chk("bresp_okay", {30'd0, bresp}, 32'd0);
        repeat (hold) begin
            @(negedge clk);
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
            chk("no_accept_in_hold", {31'd0, awready}, 32'd0);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("bvalid_down", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [5:0] a, input string tag);
        int n;
        logic [31:0] exp;
        @(negedge clk);
        araddr = a; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk({tag, ".arready"}, {31'd0, arready}, 32'd1);
        exp = m_read(a);
        @(negedge clk);
        arvalid = 0;
        chk({tag, ".rvalid"}, {31'd0, rvalid}, 32'd1);
        chk({tag, ".rdata"}, rdata, exp);
        chk({tag, ".rresp"}, {30'd0, rresp}, 32'd0);
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        ap_done = 1;
        m_done_evt();
        @(negedge clk);
        ap_done = 0;
    endtask

    task automatic check_reset_outs();
        chk("rst.awready", {31'd0, awready}, 32'd0);
        chk("rst.wready", {31'd0, wready}, 32'd0);
        chk("rst.arready", {31'd0, arready}, 32'd0);
        chk("rst.bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst.rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst.resp", {28'd0, bresp, rresp}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.ap_start", {31'd0, ap_start}, 32'd0);
        chk("rst.cfg_k_dim", cfg_k_dim, 32'd192);
        chk("rst.irq", {31'd0, irq}, 32'd0);
    endtask

    initial begin
        logic [5:0]  a;
        logic [31:0] d;
        rst_n = 0;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0; ap_done = 0; ap_idle = 1;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_outs();
        rst_n = 1;
        @(negedge clk);

        // Basic run
        axi_write(6'h0C, 32'd64, 4'hF, 0, 0, 0);
        axi_write(6'h08, 32'd1, 4'hF, 0, 0, 0);
        axi_write(6'h00, 32'd1, 4'hF, 0, 0, 0);
        check_outs("start");
        pulse_done();
        check_outs("done");
        axi_read(6'h04, "status_after_done");
        axi_read(6'h10, "done_cnt_1");
        axi_write(6'h04, 32'd1, 4'hF, 0, 0, 0);
        check_outs("w1c");

        // Shadowing
        axi_write(6'h00, 32'd1, 4'hF, 0, 0, 0);
        axi_write(6'h0C, 32'd100, 4'hF, 0, 0, 0);
        check_outs("shadow_hold");
        axi_read(6'h0C, "k_dim_100");
        pulse_done();
        axi_write(6'h00, 32'd1, 4'hF, 0, 0, 0);
        check_outs("shadow_reload");

        // Collisions: START with done (ap_start high), then W1C with done
        axi_write(6'h00, 32'd1, 4'hF, 0, 0, 1);
        check_outs("start_vs_done");
        axi_write(6'h04, 32'd1, 4'hF, 0, 0, 1);
        axi_read(6'h04, "w1c_vs_done");
        check_outs("w1c_vs_done");

        // AXI corners
        axi_write(6'h08, 32'd0, 4'hF, 3, 0, 0);
        axi_write(6'h08, 32'd1, 4'hF, 0, 5, 0);
        axi_read(6'h1C, "unmapped_1c");
        axi_write(6'h0C, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
        axi_read(6'h0C, "wstrb_byte1");
        axi_write(6'h10, 32'h12345678, 4'hF, 0, 0, 0);
        axi_read(6'h10, "done_cnt_ro");

        // Randomised traffic against the model
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 6'($urandom_range(0, 5) * 4);
                    d = $urandom;
                    if (a == 6'h00) d[7] = 1'b0;
                    axi_write(a, d, 4'($urandom_range(0, 15)), 0, 0, 0);
                end
                1: axi_read(6'($urandom_range(0, 7) * 4), "rand_read");
                2: pulse_done();
                default: begin @(negedge clk); ap_idle = ~ap_idle; end
            endcase
            check_outs("rand");
        end
        @(negedge clk);
        ap_idle = 1;

        // Reset in the middle of a run
        axi_write(6'h0C, 32'd77, 4'hF, 0, 0, 0);
        axi_write(6'h00, 32'd1, 4'hF, 0, 0, 0);
        if (!m_start) pulse_done();
        axi_read(6'h0C, "pre_reset_read");
        @(negedge clk);
        rst_n = 0;
        #1;
        check_reset_outs();
        m_reset();
        @(negedge clk);
        rst_n = 1;
        axi_read(6'h0C, "k_dim_after_reset");
        axi_read(6'h10, "cnt_after_reset");

`ifdef CTRL_AUTO_RESTART_EN
        axi_write(6'h0C, 32'd33, 4'hF, 0, 0, 0);
        axi_write(6'h00, 32'h81, 4'hF, 0, 0, 0);
        check_outs("auto_start");
        ap_idle = 0;
        for (int r = 0; r < 2; r++) begin
            pulse_done();
            check_outs("auto_gap");
            ap_idle = 1;
            @(negedge clk);
            m_start = 1;
            m_cfg   = m_k;
            check_outs("auto_restart");
            ap_idle = 0;
        end
        axi_write(6'h00, 32'h00, 4'hF, 0, 0, 0);
        pulse_done();
        ap_idle = 1;
        repeat (2) @(negedge clk);
        check_outs("auto_off");
        axi_read(6'h10, "auto_done_cnt");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
